// File: rtl/seq_step_ctrl.sv
// Run controller for the 5-state phase sequencer: per-phase dwell timing,
// advance/reset strobes to the sequencer, repeat rounds, pause, single-step and abort.
module seq_step_ctrl #(
    parameter int DW = 8,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_addr,
    input  logic [DW-1:0] cfg_data,
    input  logic          start,
    input  logic          halt,
    input  logic          step_req,
    input  logic [RW-1:0] reps,
    output logic          adv,
    output logic          seq_rst,
    output logic [2:0]    phase,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_reg, state_next;
    logic [DW-1:0] cnt_reg, cnt_next;
    logic [2:0]    phase_reg, phase_next;
    logic [RW-1:0] rep_cnt_reg, rep_cnt_next;
    logic [RW-1:0] reps_reg, reps_next;
    logic          step_pend_reg, step_pend_next;
    logic          cfg_err_reg;

    logic          cfg_ok;
    logic [DW-1:0] dwell_arr [5];
    logic [DW-1:0] cur_dwell;
    logic [DW-1:0] term_cnt;
    logic          at_term;
    logic          last_round;

    assign cfg_ok = cfg_we && (state_reg == S_IDLE || state_reg == S_DONE)
                    && (cfg_addr <= 3'd4);

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_dwell
            logic [DW-1:0] dwell_reg;
            always_ff @(posedge clk) begin
                if (rst)
                    dwell_reg <= DW'(1);
                else if (cfg_ok && cfg_addr == 3'(gi))
                    dwell_reg <= cfg_data;
            end
            assign dwell_arr[gi] = dwell_reg;
        end
    endgenerate

    always_comb begin
        cur_dwell = dwell_arr[0];
        case (phase_reg)
            3'd1:    cur_dwell = dwell_arr[1];
            3'd2:    cur_dwell = dwell_arr[2];
            3'd3:    cur_dwell = dwell_arr[3];
            3'd4:    cur_dwell = dwell_arr[4];
            default: cur_dwell = dwell_arr[0];
        endcase
    end

    // A zero dwell behaves as one cycle, so the terminal count is max(d,1)-1.
    assign term_cnt   = (cur_dwell == '0) ? '0 : cur_dwell - DW'(1);
    assign at_term    = (cnt_reg == term_cnt);
    assign last_round = adv && (phase_reg == 3'd4) && (reps_reg != '0)
                        && (rep_cnt_reg + RW'(1) == reps_reg);

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start)
                    state_next = S_LOAD;
            end
            S_LOAD: state_next = S_RUN;
            S_RUN: begin
                if (last_round)
                    state_next = S_DONE;
                else if (halt)
                    state_next = S_PAUSE;
            end
            S_PAUSE: begin
                if (last_round)
                    state_next = S_DONE;
                else if (halt)
                    state_next = S_IDLE;
                else if (start)
                    state_next = S_RUN;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        adv     = 1'b0;
        seq_rst = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_reg)
            S_LOAD: begin
                seq_rst = 1'b1;
                busy    = 1'b1;
            end
            S_RUN: begin
                busy = 1'b1;
                adv  = at_term;
            end
            S_PAUSE: begin
                busy = 1'b1;
                adv  = step_pend_reg;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign phase   = phase_reg;
    assign cfg_err = cfg_err_reg;

    always_comb begin
        cnt_next       = cnt_reg;
        phase_next     = phase_reg;
        rep_cnt_next   = rep_cnt_reg;
        reps_next      = reps_reg;
        step_pend_next = 1'b0;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    cnt_next     = '0;
                    phase_next   = '0;
                    rep_cnt_next = '0;
                    reps_next    = reps;
                end
            end
            S_LOAD: cnt_next = '0;
            S_RUN: begin
                if (!halt)
                    cnt_next = cnt_reg + DW'(1);
            end
            S_PAUSE: begin
                // The step request becomes a one-cycle advance in the following cycle.
                if (!step_pend_reg && !halt && !start && step_req)
                    step_pend_next = 1'b1;
            end
            default: ;
        endcase
        if (adv) begin
            cnt_next   = '0;
            phase_next = (phase_reg == 3'd4) ? 3'd0 : phase_reg + 3'd1;
            if (phase_reg == 3'd4)
                rep_cnt_next = rep_cnt_reg + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg       <= '0;
            phase_reg     <= '0;
            rep_cnt_reg   <= '0;
            reps_reg      <= '0;
            step_pend_reg <= 1'b0;
            cfg_err_reg   <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            phase_reg     <= phase_next;
            rep_cnt_reg   <= rep_cnt_next;
            reps_reg      <= reps_next;
            step_pend_reg <= step_pend_next;
            cfg_err_reg   <= cfg_we && !cfg_ok;
        end
    end

endmodule

// File: tb/tb_seq_step_ctrl.sv
// Scoreboard bench for seq_step_ctrl: expected advance pulses are queued with
// their cycle and phase; a monitor pops and compares on every adv pulse.
module tb_seq_step_ctrl;
    localparam int DW = 8;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_addr = '0;
    logic [DW-1:0] cfg_data = '0;
    logic          start = 1'b0;
    logic          halt = 1'b0;
    logic          step_req = 1'b0;
    logic [RW-1:0] reps = '0;
    logic          adv, seq_rst, busy, done, cfg_err;
    logic [2:0]    phase;

    seq_step_ctrl #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .start(start), .halt(halt), .step_req(step_req),
        .reps(reps), .adv(adv), .seq_rst(seq_rst), .phase(phase),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int t; int ph; } ev_t;
    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  dw[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int eff(input int p);
        return (dw[p] == 0) ? 1 : dw[p];
    endfunction

    always @(negedge clk) begin
        ev_t e;
        if (!rst && adv) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL adv_unexpected: adv=1 at cycle %0d phase %0d, none expected", cyc, phase);
            end else begin
                e = exp_q.pop_front();
                $display("adv cycle=%0d phase=%0d (expected cycle=%0d phase=%0d)", cyc, phase, e.t, e.ph);
                chk("adv_cycle", cyc, e.t);
                chk("adv_phase", 32'(phase), e.ph);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push_ev(input int t, input int ph);
        ev_t e;
        e.t  = t;
        e.ph = ph;
        exp_q.push_back(e);
    endtask

    task automatic push_seq(input int t_prev, input int ph0, input int n, output int t_last);
        int t;
        int ph;
        t  = t_prev;
        ph = ph0;
        for (int k = 0; k < n; k++) begin
            t += eff(ph);
            push_ev(t, ph);
            ph = (ph + 1) % 5;
        end
        t_last = t;
    endtask

    task automatic do_start(input int r, output int c);
        c     = cyc;
        reps  = RW'(r);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic cfg_write(input int a, input int d, input logic exp_err);
        cfg_we   = 1'b1;
        cfg_addr = 3'(a);
        cfg_data = DW'(d);
        tick();
        cfg_we = 1'b0;
        $display("cfg write addr=%0d data=%0d cfg_err=%0b", a, d, cfg_err);
        chk("cfg_err", 32'(cfg_err), 32'(exp_err));
        tick();
        chk("cfg_err_pulse", 32'(cfg_err), 0);
    endtask

    task automatic chk_drained(input string name);
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, d, e, tl;
        int vals[5];
        for (int i = 0; i < 5; i++) dw[i] = 1;

        repeat (3) tick();
        chk("rst_adv", 32'(adv), 0);
        chk("rst_seq_rst", 32'(seq_rst), 0);
        chk("rst_phase", 32'(phase), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        rst = 1'b0;
        tick();

        // Out-of-range address in IDLE is rejected.
        cfg_write(5, 9, 1'b1);

        // Default table, one round: five back-to-back advances.
        do_start(1, c);
        chk("t1_seq_rst", 32'(seq_rst), 1);
        chk("t1_busy", 32'(busy), 1);
        push_seq(c + 1, 0, 5, tl);
        tick();
        chk("t1_seq_rst_low", 32'(seq_rst), 0);
        wait_cyc(tl + 1);
        chk("t1_done", 32'(done), 1);
        chk("t1_busy_low", 32'(busy), 0);
        chk("t1_phase", 32'(phase), 0);
        chk_drained("t1_drained");

        // Valid writes in DONE, then two rounds with dwell {3,1,2,0,4}.
        vals = '{3, 1, 2, 0, 4};
        for (int i = 0; i < 5; i++) begin
            cfg_write(i, vals[i], 1'b0);
            dw[i] = vals[i];
        end
        do_start(2, c);
        push_seq(c + 1, 0, 10, tl);
        wait_cyc(c + 13);
        chk("t2_mid_busy", 32'(busy), 1);
        chk("t2_mid_done", 32'(done), 0);
        wait_cyc(tl + 1);
        chk("t2_done", 32'(done), 1);
        chk("t2_busy_low", 32'(busy), 0);
        chk_drained("t2_drained");

        // Pause at cnt=2 of phase 1, single-step, then resume.
        for (int i = 0; i < 5; i++) begin
            cfg_write(i, 5, 1'b0);
            dw[i] = 5;
        end
        do_start(1, c);
        push_ev(c + 6, 0);
        wait_cyc(c + 9);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("t3_pause_busy", 32'(busy), 1);
        wait_cyc(c + 20);
        chk("t3_pause_phase", 32'(phase), 1);
        chk("t3_pause_busy2", 32'(busy), 1);
        chk_drained("t3_pause_drained");
        d = cyc;
        push_ev(d + 1, 1);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        chk("t3_step_phase", 32'(phase), 2);
        chk("t3_step_adv_low", 32'(adv), 0);
        e = cyc;
        push_seq(e, 2, 3, tl);
        reps  = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_cyc(tl + 1);
        chk("t3_done", 32'(done), 1);
        chk("t3_busy_low", 32'(busy), 0);
        chk_drained("t3_drained");

        // Config write during RUN is rejected and does not alter timing.
        do_start(1, c);
        push_seq(c + 1, 0, 5, tl);
        wait_cyc(c + 4);
        cfg_write(0, 1, 1'b1);
        wait_cyc(tl + 1);
        chk("t4_done", 32'(done), 1);
        chk_drained("t4_drained");

        // Continuous run for three rounds, then pause and abort.
        for (int i = 0; i < 5; i++) begin
            cfg_write(i, 2, 1'b0);
            dw[i] = 2;
        end
        do_start(0, c);
        push_seq(c + 1, 0, 15, tl);
        wait_cyc(c + 12);
        chk("t5_r1_done", 32'(done), 0);
        wait_cyc(c + 22);
        chk("t5_r2_done", 32'(done), 0);
        wait_cyc(tl + 1);
        chk("t5_r3_done", 32'(done), 0);
        chk("t5_r3_busy", 32'(busy), 1);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("t5_pause_busy", 32'(busy), 1);
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("t5_abort_busy", 32'(busy), 0);
        chk("t5_abort_done", 32'(done), 0);
        chk("t5_abort_adv", 32'(adv), 0);
        chk_drained("t5_drained");

        // Halt in the same cycle as an advance.
        do_start(0, c);
        push_seq(c + 1, 0, 2, tl);
        wait_cyc(tl);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("t6_phase", 32'(phase), 2);
        chk("t6_adv", 32'(adv), 0);
        chk("t6_busy", 32'(busy), 1);
        chk("t6_done", 32'(done), 0);
        wait_cyc(c + 11);
        chk("t6_frozen_phase", 32'(phase), 2);
        chk_drained("t6_drained");
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("t6_abort_busy", 32'(busy), 0);

        // Reset during phase 3 of a run; table returns to all ones.
        do_start(0, c);
        push_seq(c + 1, 0, 3, tl);
        wait_cyc(c + 8);
        chk("t7_phase3", 32'(phase), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t7_adv", 32'(adv), 0);
        chk("t7_seq_rst", 32'(seq_rst), 0);
        chk("t7_phase", 32'(phase), 0);
        chk("t7_busy", 32'(busy), 0);
        chk("t7_done", 32'(done), 0);
        chk("t7_cfg_err", 32'(cfg_err), 0);
        chk_drained("t7_drained");
        for (int i = 0; i < 5; i++) dw[i] = 1;
        do_start(1, c);
        push_seq(c + 1, 0, 5, tl);
        wait_cyc(tl + 1);
        chk("t7_table_done", 32'(done), 1);
        chk_drained("t7_table_drained");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
